game_state_uart_rx: RTL and testbench
=====================================

// Module: game_state_uart_rx
// PURPOSE
//  Receive end of the game-state byte link. Deserialises 8N1 UART frames on
//  rx and passes every received byte out. Decodes game-state messages into a
//  level-type run flag plus start/stop event pulses.
//  Sits between the board's UART RX pin and the game control logic. It is the
//  counterpart of the block that encodes switch position into the game-state byte.
// PARAMETERS
//  CLKS_PER_BIT  16  uart_clk cycles per UART bit; even, >= 4
//  SYNC_STAGES   2   flops in the rx input synchroniser; >= 2
// PORTS
//  uart_clk      in   1  sole clock; all logic on its rising edge
//  rst           in   1  asynchronous, active-high reset
//  rx            in   1  serial input, idle high, async to uart_clk
//  rx_byte       out  8  last good byte; held until the next good byte
//  byte_valid    out  1  1-cycle pulse: rx_byte updated this cycle
//  framing_err   out  1  1-cycle pulse: stop bit sampled low, byte dropped
//  game_running  out  1  level: 1 after START msg, 0 after STOP msg
//  start_pulse   out  1  1-cycle pulse on a decoded START msg
//  stop_pulse    out  1  1-cycle pulse on a decoded STOP msg
//  state_err     out  1  1-cycle pulse: channel 01 with illegal state code
// BEHAVIOUR
//  Reset: every output is 0. FSM = IDLE, counters = 0, synchroniser flops = 1.
//  rx passes through SYNC_STAGES flops. FSM acts on the synchronised rxs.
//  FSM states are IDLE, START, DATA, STOP and WAIT_HIGH:
//   IDLE: rxs==0 -> START, clear bit-timer.
//   START: at timer==CLKS_PER_BIT/2-1 (mid start bit) sample rxs.
//     If rxs==1 (glitch), go to IDLE with no pulse.
//     Otherwise clear the timer and go to DATA.
//   DATA: sample rxs at every timer==CLKS_PER_BIT-1, LSB first, into a shift register.
//     After the 8th sample go to STOP.
//   STOP: sample at timer==CLKS_PER_BIT-1.
//     rxs==1: load rx_byte, pulse byte_valid, run the decode, go to IDLE.
//     rxs==0: pulse framing_err, leave rx_byte unchanged, go to WAIT_HIGH.
//   WAIT_HIGH: stay until rxs==1, then go to IDLE. A held-low line (break)
//     gives exactly one framing_err.
//  Timer width is $clog2(CLKS_PER_BIT). The timer wraps to 0 at CLKS_PER_BIT-1.
//  Latency: byte_valid rises SYNC_STAGES+1 cycles after the rx edge that
//   ends the mid-stop sample window. No back-pressure and no buffering: the
//   consumer must take rx_byte within one byte time (10*CLKS_PER_BIT cycles).
//  Decode uses the stop-bit edge and the same byte as rx_byte:
//   byte[1:0]==2'b01 is the game-state channel. Bits [7:4] are don't-care.
//     byte[3:2]==2'b01: game_running<=1 and pulse start_pulse (pulses even if already running).
//     byte[3:2]==2'b10: game_running<=0 and pulse stop_pulse (pulses even if already stopped).
//     byte[3:2]==2'b00 or 2'b11: pulse state_err; game_running unchanged.
//   Any other channel: pulse byte_valid only; no decode output changes.
//  Decode outputs change on the same edge byte_valid rises; all pulses are
//   registered. Back-to-back frames are legal: the next start bit may be
//   detected on the cycle after the STOP sample.
//  A reset asserted mid-frame discards the partial byte and clears all
//   outputs immediately. After release, a frame already in flight is seen as
//   starting wherever rx next goes low. Its data bits are unsynchronised and
//   the bench must not check them.
// STRUCTURE
//  Package game_proto_pkg holds:
//   CH_GAME_STATE = 2'b01
//   ST_START = 2'b01, ST_STOP = 2'b10
//   GAME_START = 8'b0000_01_01, GAME_STOP = 8'b0000_10_01
//   the rx FSM state encoding
//  The transmit-side encoder imports the same package.
//  One sub-module, uart_rx_core: synchroniser, timer and FSM. It emits
//   byte, byte_valid and framing_err. The top adds the registered decode.
// TESTING
//  1 Reset: hold rst with rx=1. All outputs 0. Release, idle 100 cycles -> no pulses.
//  2 Send 8'h05 (START), then 8'h09 (STOP), each at 16 clks/bit:
//    byte_valid x2; rx_byte=05 then 09.
//    game_running 0->1->0; one start_pulse, then one stop_pulse.
//  3 Send 8'hF5 -> START decoded (upper nibble ignored).
//    Then send 8'h01 and 8'h0D -> two state_err pulses, game_running stays 1.
//  4 Send 8'hA6 (channel 10) -> byte_valid, rx_byte=A6, no decode pulse.
//    Then force stop bit 0 on 8'h05 -> framing_err, rx_byte stays A6,
//    game_running unchanged.
//  5 Pulse rx low for 4 cycles (glitch) -> no outputs.
//    Hold rx low 400 cycles -> exactly one framing_err; 8'h05 afterwards decodes normally.
//  6 Assert rst during bit 3 of 8'h05 -> outputs 0.
//    Release with rx=1, then send 8'h09 -> rx_byte=09, stop_pulse=1.

Source files
------------

// File: rtl/game_proto_pkg.sv
// Shared game-state byte protocol constants and rx FSM encoding.
// Imported by both the link receiver and the switch-side encoder.
package game_proto_pkg;

    localparam logic [1:0] CH_GAME_STATE = 2'b01;
    localparam logic [1:0] ST_START      = 2'b01;
    localparam logic [1:0] ST_STOP       = 2'b10;

    localparam logic [7:0] GAME_START = 8'b0000_01_01;
    localparam logic [7:0] GAME_STOP  = 8'b0000_10_01;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserialiser: input synchroniser, bit timer and frame FSM.
// Also exposes the good-stop strobe and low nibble so decode can share the edge.
module uart_rx_core
    import game_proto_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       uart_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_err,
    output logic       good_stb,
    output logic [3:0] dec_bits
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_q  <= RX_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    timer_q <= '0;
                    if (!rxs) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer_q == T_HALF) begin
                        timer_q  <= '0;
                        bitcnt_q <= '0;
                        state_q  <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer_q == T_LAST) begin
                        timer_q  <= '0;
                        shift_q  <= {rxs, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer_q == T_LAST) begin
                        timer_q <= '0;
                        if (rxs) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= RX_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= RX_WAIT_HIGH;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign good_stb    = (state_q == RX_STOP) && (timer_q == T_LAST) && rxs;
    assign dec_bits    = shift_q[3:0];
    assign rx_byte     = byte_q;
    assign byte_valid  = valid_q;
    assign framing_err = ferr_q;

endmodule

// File: rtl/game_state_uart_rx.sv
// Game-state link receiver: UART byte stream plus registered START/STOP decode.
// Decode registers load on the same edge as the received byte.
module game_state_uart_rx
    import game_proto_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       uart_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_err,
    output logic       game_running,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       state_err
);

    logic       good_stb;
    logic [3:0] dec_bits;

    logic run_q;
    logic start_q;
    logic stop_q;
    logic serr_q;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_core (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .framing_err(framing_err),
        .good_stb   (good_stb),
        .dec_bits   (dec_bits)
    );

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            serr_q  <= 1'b0;
            if (good_stb && dec_bits[1:0] == CH_GAME_STATE) begin
                case (dec_bits[3:2])
                    ST_START: begin
                        run_q   <= 1'b1;
                        start_q <= 1'b1;
                    end
                    ST_STOP: begin
                        run_q  <= 1'b0;
                        stop_q <= 1'b1;
                    end
                    default: serr_q <= 1'b1;
                endcase
            end
        end
    end

    assign game_running = run_q;
    assign start_pulse  = start_q;
    assign stop_pulse   = stop_q;
    assign state_err    = serr_q;

endmodule

// File: tb/tb_game_state_uart_rx.sv
// Directed bench for the game-state UART receiver.
// Pulses are tallied on the falling edge; each step compares tally deltas.
module tb_game_state_uart_rx;

    localparam int CPB = 16;

    logic       uart_clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       framing_err;
    logic       game_running;
    logic       start_pulse;
    logic       stop_pulse;
    logic       state_err;

    int checks;
    int errors;
    int n_bv, n_fe, n_st, n_sp, n_se;
    int b_bv, b_fe, b_st, b_sp, b_se;

    game_state_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .uart_clk    (uart_clk),
        .rst         (rst),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .framing_err (framing_err),
        .game_running(game_running),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .state_err   (state_err)
    );

    initial uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    always @(negedge uart_clk) begin
        if (byte_valid)  n_bv++;
        if (framing_err) n_fe++;
        if (start_pulse) n_st++;
        if (stop_pulse)  n_sp++;
        if (state_err)   n_se++;
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_bv = n_bv; b_fe = n_fe; b_st = n_st; b_sp = n_sp; b_se = n_se;
    endtask

    task automatic deltas(input string tag, input int bv, input int fe,
                          input int st, input int sp, input int se);
        check({tag, ".bv"}, 8'(n_bv - b_bv), 8'(bv));
        check({tag, ".fe"}, 8'(n_fe - b_fe), 8'(fe));
        check({tag, ".st"}, 8'(n_st - b_st), 8'(st));
        check({tag, ".sp"}, 8'(n_sp - b_sp), 8'(sp));
        check({tag, ".se"}, 8'(n_se - b_se), 8'(se));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge uart_clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge uart_clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        n_bv = 0; n_fe = 0; n_st = 0; n_sp = 0; n_se = 0;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge uart_clk);
        #1;
        check("rst.byte", rx_byte, 8'h00);
        check("rst.outs", {2'b0, byte_valid, framing_err, game_running,
              start_pulse, stop_pulse, state_err}, 8'h00);
        rst = 1'b0;
        snap();
        idle(100);
        deltas("idle", 0, 0, 0, 0, 0);

        // START then STOP
        snap();
        send(8'h05, 1'b1); idle(20);
        deltas("t2a", 1, 0, 1, 0, 0);
        check("t2a.byte", rx_byte, 8'h05);
        check("t2a.run", {7'b0, game_running}, 8'h01);
        snap();
        send(8'h09, 1'b1); idle(20);
        deltas("t2b", 1, 0, 0, 1, 0);
        check("t2b.byte", rx_byte, 8'h09);
        check("t2b.run", {7'b0, game_running}, 8'h00);

        // upper nibble ignored, then illegal state codes
        snap();
        send(8'hF5, 1'b1); idle(20);
        deltas("t3a", 1, 0, 1, 0, 0);
        check("t3a.run", {7'b0, game_running}, 8'h01);
        snap();
        send(8'h01, 1'b1); idle(4);
        send(8'h0D, 1'b1); idle(20);
        deltas("t3b", 2, 0, 0, 0, 2);
        check("t3b.byte", rx_byte, 8'h0D);
        check("t3b.run", {7'b0, game_running}, 8'h01);

        // other channel, then framing error
        snap();
        send(8'hA6, 1'b1); idle(20);
        deltas("t4a", 1, 0, 0, 0, 0);
        check("t4a.byte", rx_byte, 8'hA6);
        snap();
        send(8'h05, 1'b0); idle(20);
        deltas("t4b", 0, 1, 0, 0, 0);
        check("t4b.byte", rx_byte, 8'hA6);
        check("t4b.run", {7'b0, game_running}, 8'h01);

        // glitch, break, recovery
        snap();
        rx = 1'b0;
        repeat (4) @(posedge uart_clk);
        idle(60);
        deltas("glitch", 0, 0, 0, 0, 0);
        snap();
        rx = 1'b0;
        repeat (400) @(posedge uart_clk);
        idle(30);
        deltas("break", 0, 1, 0, 0, 0);
        snap();
        send(8'h09, 1'b1); idle(10);
        send(8'h05, 1'b1); idle(20);
        deltas("recov", 2, 0, 1, 1, 0);
        check("recov.byte", rx_byte, 8'h05);
        check("recov.run", {7'b0, game_running}, 8'h01);

        // reset mid-frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(posedge uart_clk);
        #2 rst = 1'b1;
        #1;
        check("t6.byte", rx_byte, 8'h00);
        check("t6.outs", {2'b0, byte_valid, framing_err, game_running,
              start_pulse, stop_pulse, state_err}, 8'h00);
        rx = 1'b1;
        repeat (3) @(posedge uart_clk);
        #1 rst = 1'b0;
        idle(40);
        snap();
        send(8'h09, 1'b1); idle(20);
        deltas("t6", 1, 0, 0, 1, 0);
        check("t6b.byte", rx_byte, 8'h09);
        check("t6b.run", {7'b0, game_running}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
